// File: rtl/pb_pkg.sv
// Shared types and widths for the parallel-bus command path.
// The UART command parser uses the same address/data widths.
package pb_pkg;

    localparam int PB_ADDR_W = 3;
    localparam int PB_DATA_W = 8;

    typedef enum logic [2:0] {
        BRESET = 3'd0,
        IDLE   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        RESP   = 3'd5
    } pb_state_t;

endpackage

// File: rtl/pb_bus_sequencer.sv
// Runs one timed read/write cycle on the board's parallel bus per accepted command,
// and owns the board reset sequence (power-up and on request).
module pb_bus_sequencer
    import pb_pkg::*;
#(
    parameter int RESET_CYCLES  = 100,
    parameter int SETUP_CYCLES  = 3,
    parameter int STROBE_CYCLES = 6,
    parameter int HOLD_CYCLES   = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 reset_req,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic                 cmd_test,
    input  logic [PB_ADDR_W-1:0] cmd_addr,
    input  logic [PB_DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [PB_DATA_W-1:0] rsp_rdata,
    output logic [PB_DATA_W-1:0] bus_data_out,
    output logic                 bus_data_oe,
    input  logic [PB_DATA_W-1:0] bus_data_in,
    output logic [PB_ADDR_W-1:0] bus_addr,
    output logic                 bus_test_addr,
    output logic                 bus_rd,
    output logic                 bus_wr,
    output logic                 bus_b0,
    output logic                 bus_reset
);

    localparam int MAX_AB = (RESET_CYCLES > SETUP_CYCLES) ? RESET_CYCLES : SETUP_CYCLES;
    localparam int MAX_CD = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

    pb_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic             pend;
    logic             req_any;

    assign req_any = pend | reset_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BRESET;
            cnt           <= '0;
            wr_q          <= 1'b0;
            pend          <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            bus_data_out  <= '0;
            bus_data_oe   <= 1'b0;
            bus_addr      <= '0;
            bus_test_addr <= 1'b0;
            bus_rd        <= 1'b0;
            bus_wr        <= 1'b0;
            bus_b0        <= 1'b0;
            bus_reset     <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            // Requests arriving mid-cycle wait until the cycle would return to IDLE.
            if (reset_req && state != IDLE)
                pend <= 1'b1;

            case (state)
                // The board reset counts up from the reset value of the shared counter;
                // the bus-cycle states load and count down.
                BRESET: begin
                    if (cnt == RST_LAST) begin
                        cnt <= '0;
                        if (req_any) begin
                            pend <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            bus_reset <= 1'b0;
                            bus_b0    <= 1'b1;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (reset_req) begin
                        state     <= BRESET;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        bus_reset <= 1'b1;
                        bus_b0    <= 1'b0;
                    end else if (cmd_valid) begin
                        state         <= SETUP;
                        cnt           <= SETUP_LD;
                        cmd_ready     <= 1'b0;
                        wr_q          <= cmd_write;
                        bus_addr      <= cmd_addr;
                        bus_test_addr <= cmd_test;
                        bus_data_oe   <= cmd_write;
                        rsp_rdata     <= '0;
                        if (cmd_write)
                            bus_data_out <= cmd_wdata;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= STROBE;
                        cnt    <= STROBE_LD;
                        bus_wr <= wr_q;
                        bus_rd <= ~wr_q;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state  <= HOLD;
                        cnt    <= HOLD_LD;
                        bus_wr <= 1'b0;
                        bus_rd <= 1'b0;
                        if (!wr_q)
                            rsp_rdata <= bus_data_in;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= wr_q;
                        bus_data_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (req_any) begin
                        state     <= BRESET;
                        cnt       <= '0;
                        pend      <= 1'b0;
                        bus_reset <= 1'b1;
                        bus_b0    <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= BRESET;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_bus_sequencer.sv
// Randomized command stream against a cycle-offset model of the bus timing,
// plus directed power-up, reset-request, collision and abort scenarios.
module tb_pb_bus_sequencer;

    localparam int S     = 3;
    localparam int W     = 6;
    localparam int H     = 3;
    localparam int R     = 100;
    localparam int RSP_K = S + W + H;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       reset_req = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic       cmd_test = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;
    logic [7:0] bus_data_in = '0;
    logic [2:0] bus_addr;
    logic       bus_test_addr;
    logic       bus_rd;
    logic       bus_wr;
    logic       bus_b0;
    logic       bus_reset;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_acc = -1;

    pb_bus_sequencer #(
        .RESET_CYCLES(R), .SETUP_CYCLES(S), .STROBE_CYCLES(W), .HOLD_CYCLES(H)
    ) dut (
        .clock(clock), .reset_n(reset_n), .reset_req(reset_req),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_test(cmd_test), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
        .bus_addr(bus_addr), .bus_test_addr(bus_test_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_b0(bus_b0), .bus_reset(bus_reset)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Counts clock edges from now until bus_reset falls.
    task automatic measure_breset(input string tag);
        int n;
        n = 0;
        while (bus_reset && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, n, R);
        chk("b0_after_breset", int'(bus_b0), 1);
        chk("ready_after_breset", int'(cmd_ready), 1);
        last_acc = -1;
    endtask

    // mode 0: normal; 1: reset_req pulse during HOLD; 2: reset_n dropped mid-STROBE.
    task automatic do_cmd(input logic wr, input logic tst, input logic [2:0] a,
                          input logic [7:0] d, input logic [7:0] rdv, input int mode);
        logic [7:0] din [0:RSP_K+1];
        int w, acc;
        logic strb;
        for (int i = 0; i <= RSP_K + 1; i++) din[i] = 8'($urandom);
        din[S+W-1] = rdv;
        w = 0;
        while (!cmd_ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
        cmd_write = wr; cmd_test = tst; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        acc = cyc;
        if (last_acc >= 0) chk("b2b_gap", acc - last_acc, RSP_K + 2);
        last_acc = (mode == 0) ? acc : -1;
        for (int k = 0; k <= RSP_K + 1; k++) begin
            @(negedge clock);
            strb = (k >= S) && (k < S + W);
            chk("bus_wr", int'(bus_wr), int'(wr && strb));
            chk("bus_rd", int'(bus_rd), int'(!wr && strb));
            chk("bus_oe", int'(bus_data_oe), int'(wr && k < RSP_K));
            chk("bus_addr", int'(bus_addr), int'(a));
            chk("bus_test", int'(bus_test_addr), int'(tst));
            if (wr) chk("bus_dout", int'(bus_data_out), int'(d));
            chk("rsp_valid", int'(rsp_valid), int'(k == RSP_K));
            if (k == RSP_K) begin
                chk("rsp_write", int'(rsp_write), int'(wr));
                chk("rsp_rdata", int'(rsp_rdata), wr ? 0 : int'(rdv));
            end
            if (k <= RSP_K) chk("ready_busy", int'(cmd_ready), 0);
            else begin
                chk("ready_end", int'(cmd_ready), int'(mode != 1));
                chk("breset_end", int'(bus_reset), int'(mode == 1));
            end
            cmd_valid = 1'b0;
            bus_data_in = din[k];
            reset_req = (mode == 1) && (k == RSP_K - 2);
            if (mode == 2 && k == S + 2) begin
                #2 reset_n = 1'b0;
                #1;
                chk("abort_wr", int'(bus_wr), 0);
                chk("abort_oe", int'(bus_data_oe), 0);
                chk("abort_breset", int'(bus_reset), 1);
                repeat (RSP_K) begin
                    @(negedge clock);
                    if (rsp_valid) chk("abort_rsp", int'(rsp_valid), 0);
                end
                reset_n = 1'b1;
                measure_breset("abort_breset_len");
                return;
            end
        end
        if (mode == 1) measure_breset("req_breset_len");
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_bus_reset", int'(bus_reset), 1);
        chk("rst_b0", int'(bus_b0), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_rsp", int'({rsp_valid, rsp_write, rsp_rdata}), 0);
        chk("rst_strobes", int'({bus_rd, bus_wr, bus_data_oe}), 0);
        chk("rst_bus", int'({bus_data_out, bus_addr, bus_test_addr}), 0);
        reset_n = 1'b1;
        measure_breset("pwr_breset_len");

        do_cmd(1'b1, 1'b1, 3'd5, 8'hA7, 8'h00, 0);
        do_cmd(1'b0, 1'b0, 3'd2, 8'h00, 8'h3C, 0);
        for (int i = 0; i < 16; i++)
            do_cmd(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 0);

        do_cmd(1'b1, 1'b0, 3'd6, 8'h5A, 8'h00, 1);

        // reset_req and cmd_valid together in IDLE: the request wins
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b1; reset_req = 1'b1;
        @(negedge clock);
        chk("coll_ready", int'(cmd_ready), 0);
        chk("coll_breset", int'(bus_reset), 1);
        chk("coll_oe", int'(bus_data_oe), 0);
        cmd_valid = 1'b0; reset_req = 1'b0;
        measure_breset("coll_breset_len");

        do_cmd(1'b1, 1'b1, 3'd1, 8'hC3, 8'h00, 2);
        do_cmd(1'b0, 1'b1, 3'd7, 8'h00, 8'h81, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
